// File: rtl/pipe_wall.sv
// Parametrised pipeline register wall: per-stage valid/payload with stall (hold) and flush (bubble).
// Optional performance counters are built when PIPE_WALL_PERF_EN is defined.
module pipe_wall #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 3
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   iVALID,
   input  logic [WIDTH-1:0]       iDATA,
   input  logic [DEPTH-1:0]       iSTALL,
   input  logic [DEPTH-1:0]       iFLUSH,
   output logic                   oVALID,
   output logic [WIDTH-1:0]       oDATA,
   output logic [DEPTH-1:0]       oTAP_VALID,
   output logic [DEPTH*WIDTH-1:0] oTAP_DATA
`ifdef PIPE_WALL_PERF_EN
   ,
   output logic [15:0]            oSTALL_COUNT,
   output logic [15:0]            oBUBBLE_COUNT
`endif
);

   // Handshake: iVALID qualifies iDATA; there is no ready. While stage 0 is held
   // (any stall at or above it) the capture is skipped, so upstream keeps
   // iVALID/iDATA stable until the hold drops. Stage k passes its content to
   // stage k+1 only when stage k itself is not held.

   logic [DEPTH-1:0] stageValid;
   logic [WIDTH-1:0] stageData [DEPTH];
   logic [DEPTH-1:0] holdEff;
   logic [DEPTH-1:0] flushEff;
   logic [DEPTH-1:0] srcValid;
   logic [WIDTH-1:0] srcData [DEPTH];

   // Stall and flush both propagate from older stages toward younger ones.
   always_comb begin
      holdEff  = '0;
      flushEff = '0;
      holdEff[DEPTH-1]  = iSTALL[DEPTH-1];
      flushEff[DEPTH-1] = iFLUSH[DEPTH-1];
      for (int k = DEPTH - 2; k >= 0; k--) begin
         holdEff[k]  = holdEff[k+1] | iSTALL[k];
         flushEff[k] = flushEff[k+1] | iFLUSH[k];
      end
   end

   // A held predecessor feeding an unheld stage appears as a bubble.
   always_comb begin
      srcValid   = '0;
      srcValid[0] = iVALID;
      srcData[0]  = iDATA;
      for (int k = 1; k < DEPTH; k++) begin
         srcValid[k] = stageValid[k-1] & ~holdEff[k-1];
         srcData[k]  = stageData[k-1];
      end
   end

   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stageValid <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            stageData[k] <= '0;
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (flushEff[k]) begin
               stageValid[k] <= 1'b0;
            end else if (!holdEff[k]) begin
               stageValid[k] <= srcValid[k];
               if (srcValid[k]) begin
                  stageData[k] <= srcData[k];
               end
            end
         end
      end
   end

   assign oVALID     = stageValid[DEPTH-1];
   assign oDATA      = stageData[DEPTH-1];
   assign oTAP_VALID = stageValid;

   for (genvar g = 0; g < DEPTH; g++) begin : gTap
      assign oTAP_DATA[g*WIDTH +: WIDTH] = stageData[g];
   end

`ifdef PIPE_WALL_PERF_EN
   // Saturating counters; only reset clears them.
   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         oSTALL_COUNT  <= '0;
         oBUBBLE_COUNT <= '0;
      end else begin
         if ((|iSTALL) && (oSTALL_COUNT != 16'hFFFF)) begin
            oSTALL_COUNT <= oSTALL_COUNT + 16'd1;
         end
         if (!stageValid[DEPTH-1] && (oBUBBLE_COUNT != 16'hFFFF)) begin
            oBUBBLE_COUNT <= oBUBBLE_COUNT + 16'd1;
         end
      end
   end
`endif

endmodule
